// File: rtl/matmul_pkg.sv
// Shared matmul constants and the transposer FSM state type.
package matmul_pkg;

    localparam int MAC_NUM    = 8;
    localparam int DATA_WIDTH = 64;
    localparam int ELEM_WIDTH = DATA_WIDTH / MAC_NUM;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        DRAIN = 3'd2,
        EMIT  = 3'd3,
        DONE  = 3'd4
    } tr_state_e;

endpackage

// File: rtl/tr_row_buf.sv
// Row buffer for one tile plus the column/row select mux feeding col_data.
module tr_row_buf #(
    parameter int MAC_NUM    = matmul_pkg::MAC_NUM,
    parameter int DATA_WIDTH = matmul_pkg::DATA_WIDTH,
    parameter int ELEM_WIDTH = matmul_pkg::ELEM_WIDTH,
    parameter int ADDR_WIDTH = $clog2(MAC_NUM)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_WIDTH-1:0] sel_i,
    input  logic                  row_mode_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [DATA_WIDTH-1:0] rows_q [MAC_NUM];
    logic [DATA_WIDTH-1:0] col_word;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < MAC_NUM; i++) begin
                rows_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            rows_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Element r of the output column comes from element sel of row r.
    generate
        for (genvar gi = 0; gi < MAC_NUM; gi++) begin : g_col
            assign col_word[gi*ELEM_WIDTH +: ELEM_WIDTH] = rows_q[gi][sel_i*ELEM_WIDTH +: ELEM_WIDTH];
        end
    endgenerate

    assign data_o = row_mode_i ? rows_q[sel_i] : col_word;

endmodule

// File: rtl/temp_transposer.sv
// Reads one MAC_NUM x MAC_NUM tile from the temp buffer and emits it column by column.
// Optional TRANSPOSER_ROW_MODE_EN adds row_mode_i to emit rows unchanged instead.
module temp_transposer #(
    parameter int MAC_NUM      = matmul_pkg::MAC_NUM,
    parameter int DATA_WIDTH   = matmul_pkg::DATA_WIDTH,
    localparam int ELEM_WIDTH  = DATA_WIDTH / MAC_NUM,
    localparam int ADDR_WIDTH  = $clog2(MAC_NUM)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
`ifdef TRANSPOSER_ROW_MODE_EN
    input  logic                  row_mode_i,
`endif
    input  logic                  wr_temp_en_i,
    output logic                  rd_temp_en_o,
    output logic [ADDR_WIDTH-1:0] rd_temp_addr_o,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic                  col_valid_o,
    input  logic                  col_ready_i,
    output logic [DATA_WIDTH-1:0] col_data_o,
    output logic [ADDR_WIDTH-1:0] col_idx_o,
    output logic                  busy_o,
    output logic                  done_o
);

    import matmul_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(MAC_NUM - 1);

    tr_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] col_idx_q, col_idx_d;
    logic                  pend_q, pend_d;
    logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
    logic                  row_mode_q;
    logic [DATA_WIDTH-1:0] buf_data;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            col_idx_q   <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            col_idx_q   <= col_idx_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
        end
    end

`ifdef TRANSPOSER_ROW_MODE_EN
    logic row_mode_d;

    assign row_mode_d = (state_q == IDLE && start_i) ? row_mode_i : row_mode_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            row_mode_q <= 1'b0;
        end else begin
            row_mode_q <= row_mode_d;
        end
    end
`else
    assign row_mode_q = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        col_idx_d    = col_idx_q;
        pend_d       = 1'b0;
        pend_addr_d  = addr_q;
        rd_temp_en_o = 1'b0;
        col_valid_o  = 1'b0;
        done_o       = 1'b0;
        busy_o       = (state_q != IDLE) && (state_q != DONE);

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = FETCH;
                    addr_d    = '0;
                    col_idx_d = '0;
                end
            end
            FETCH: begin
                // A concurrent buffer write wins the port; hold the address and retry.
                if (!wr_temp_en_i) begin
                    rd_temp_en_o = 1'b1;
                    pend_d       = 1'b1;
                    if (addr_q == LAST_IDX) begin
                        addr_d  = '0;
                        state_d = DRAIN;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (pend_q) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                col_valid_o = 1'b1;
                if (col_ready_i) begin
                    if (col_idx_q == LAST_IDX) begin
                        col_idx_d = '0;
                        state_d   = DONE;
                    end else begin
                        col_idx_d = col_idx_q + 1'b1;
                    end
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    tr_row_buf #(
        .MAC_NUM    (MAC_NUM),
        .DATA_WIDTH (DATA_WIDTH),
        .ELEM_WIDTH (ELEM_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_row_buf (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wr_en_i    (pend_q),
        .wr_addr_i  (pend_addr_q),
        .wr_data_i  (rd_data_i),
        .sel_i      (col_idx_q),
        .row_mode_i (row_mode_q),
        .data_o     (buf_data)
    );

    assign rd_temp_addr_o = addr_q;
    assign col_idx_o      = col_idx_q;
    assign col_data_o     = (state_q == EMIT) ? buf_data : '0;

endmodule

// File: tb/tb_temp_transposer.sv
// Directed bench for temp_transposer: a temp-buffer model answers reads, columns are checked per cycle.
module tb_temp_transposer;

    localparam int N  = 8;
    localparam int DW = 64;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic          col_valid;
    logic          col_ready = 1'b1;
    logic [DW-1:0] col_data;
    logic [AW-1:0] col_idx;
    logic          busy;
    logic          done;
`ifdef TRANSPOSER_ROW_MODE_EN
    logic          row_mode = 1'b0;
`endif

    int            errors = 0;
    int            checks = 0;
    bit            row_mode_exp = 1'b0;
    logic [DW-1:0] mem [N];
    logic [DW-1:0] seen_cols [N];

    always #5 clk = ~clk;

    temp_transposer dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
`ifdef TRANSPOSER_ROW_MODE_EN
        .row_mode_i     (row_mode),
`endif
        .wr_temp_en_i   (wr_en),
        .rd_temp_en_o   (rd_en),
        .rd_temp_addr_o (rd_addr),
        .rd_data_i      (rd_data),
        .col_valid_o    (col_valid),
        .col_ready_i    (col_ready),
        .col_data_o     (col_data),
        .col_idx_o      (col_idx),
        .busy_o         (busy),
        .done_o         (done)
    );

    // Temp buffer model: data one cycle after an accepted read.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Byte e of row r is {r,e}; column c therefore has byte r = {r,c}.
    function automatic logic [63:0] exp_col(input int c, input bit rowm);
        logic [63:0] w;
        logic [3:0]  cn;
        logic [3:0]  rn;
        w  = '0;
        cn = 4'(c);
        for (int r = 0; r < N; r++) begin
            rn = 4'(r);
            w[r*8 +: 8] = rowm ? {cn, rn} : {rn, cn};
        end
        return w;
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_rd_en"}, 64'(rd_en), 64'd0);
        chk({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
        chk({tag, "_valid"}, 64'(col_valid), 64'd0);
        chk({tag, "_data"}, col_data, 64'd0);
        chk({tag, "_idx"}, 64'(col_idx), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
    endtask

    // Runs one tile from the current negedge; optional write stall, ready hold and stray start.
    task automatic run_tile(input string tag, input int stall_at, input int stall_len,
                            input int hold_at, input int hold_len, input bit mid_start,
                            output int lat);
        int  cyc, k, nd, na, post, stall_cnt, hold_cnt;
        bit  stalled, held, stray_done;
        lat = -1; k = 0; nd = 0; na = 0; post = 0; stall_cnt = 0; hold_cnt = 0;
        stalled = 0; held = 0; stray_done = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 200 && post < 4) begin
            start = 1'b0;
            wr_en = 1'b0;
            col_ready = 1'b1;
            if (stall_cnt > 0) begin
                wr_en = 1'b1;
                stall_cnt--;
            end else if (!stalled && stall_len > 0 && busy && lat < 0 && int'(rd_addr) == stall_at) begin
                stalled = 1; wr_en = 1'b1; stall_cnt = stall_len - 1;
            end
            if (hold_cnt > 0) begin
                col_ready = 1'b0;
                hold_cnt--;
            end else if (!held && hold_len > 0 && col_valid && int'(col_idx) == hold_at) begin
                held = 1; col_ready = 1'b0; hold_cnt = hold_len - 1;
            end
            if (mid_start && !stray_done && col_valid && col_idx == 3'd2) begin
                stray_done = 1; start = 1'b1;
            end
            #1;
            if (wr_en) begin
                chk({tag, "_stall_rd_en"}, 64'(rd_en), 64'd0);
                chk({tag, "_stall_addr"}, 64'(rd_addr), 64'(stall_at));
            end
            if (rd_en) begin
                chk({tag, "_rd_addr"}, 64'(rd_addr), 64'(na));
                na++;
            end
            if (col_valid) begin
                if (lat < 0) lat = cyc;
                chk({tag, "_col_idx"}, 64'(col_idx), 64'(k));
                chk({tag, "_col_data"}, col_data, exp_col(k, row_mode_exp));
                if (col_ready) begin
                    if (k < N) seen_cols[k] = col_data;
                    k++;
                end
            end
            if (done) begin
                nd++;
                chk({tag, "_done_busy"}, 64'(busy), 64'd0);
                chk({tag, "_done_cols"}, 64'(k), 64'(N));
            end
            if (nd > 0) post++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        wr_en = 1'b0;
        col_ready = 1'b1;
        chk({tag, "_reads"}, 64'(na), 64'(N));
        chk({tag, "_cols"}, 64'(k), 64'(N));
        chk({tag, "_done_count"}, 64'(nd), 64'd1);
        chk({tag, "_idle_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int lat;
        int guard;
        bit found;
        for (int r = 0; r < N; r++) begin
            for (int e = 0; e < N; e++) begin
                logic [3:0] rn, en;
                rn = 4'(r);
                en = 4'(e);
                mem[r][e*8 +: 8] = {rn, en};
            end
        end

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("reset");

        // Basic tile, always ready
        run_tile("basic", -1, 0, -1, 0, 1'b0, lat);
        chk("basic_latency", 64'(lat), 64'(N + 2));
        chk("basic_col3", seen_cols[3], 64'h7363534333231303);

        // Two-cycle write stall at address 4
        run_tile("stall", 4, 2, -1, 0, 1'b0, lat);
        chk("stall_latency", 64'(lat), 64'(N + 4));
        chk("stall_col3", seen_cols[3], 64'h7363534333231303);

        // Consumer backpressure at column 5
        run_tile("hold", -1, 0, 5, 3, 1'b0, lat);
        chk("hold_latency", 64'(lat), 64'(N + 2));
        chk("hold_col5", seen_cols[5], exp_col(5, 1'b0));

        // Stray start during EMIT is ignored; the next start runs a fresh tile
        run_tile("midstart", -1, 0, -1, 0, 1'b1, lat);
        run_tile("restart", -1, 0, -1, 0, 1'b0, lat);
        chk("restart_latency", 64'(lat), 64'(N + 2));

        // Reset while presenting column 2
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        found = 0;
        while (guard < 50 && !found) begin
            if (col_valid && col_idx == 3'd2) found = 1;
            else begin
                @(negedge clk);
                guard++;
            end
        end
        chk("rst_reach_col2", 64'(found), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("midrst");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_no_read", 64'(rd_en), 64'd0);
            chk("midrst_no_done", 64'(done), 64'd0);
        end
        run_tile("after_rst", -1, 0, -1, 0, 1'b0, lat);
        chk("after_rst_latency", 64'(lat), 64'(N + 2));

`ifdef TRANSPOSER_ROW_MODE_EN
        row_mode = 1'b1;
        row_mode_exp = 1'b1;
        run_tile("rowmode", -1, 0, -1, 0, 1'b0, lat);
        row_mode = 1'b0;
        row_mode_exp = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
